// File: rtl/piso_serializer_if.sv
// ============================================================================
// Module     : piso_serializer_if
// Description: Word-in / bit-out handshake bundle for piso_serializer.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] parIn;
    logic             inValid;
    logic             inReady;
    logic             serOut;
    logic             serValid;
    logic             done;

    // The word producer drives the parallel side and observes the serial side.
    modport master (
        output parIn,
        output inValid,
        input  inReady,
        input  serOut,
        input  serValid,
        input  done
    );

    modport slave (
        input  parIn,
        input  inValid,
        output inReady,
        output serOut,
        output serValid,
        output done
    );
endinterface

`default_nettype wire

// File: rtl/piso_serializer.sv
// ============================================================================
// Module     : piso_serializer
// Description: Parallel-in / serial-out converter, LSB first, with done pulse.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rstN,
    piso_serializer_if.slave  bus
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("piso_serializer: WIDTH must be between 2 and 32");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [WIDTH-1:0]   shift_q,    shift_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               serOut_q,   serOut_d;
    logic               serValid_q, serValid_d;
    logic               done_q,     done_d;
    logic               inReady_q,  inReady_d;
    logic               accept;

    // inReady_q is high exactly in IDLE and DONE, so it doubles as the accept gate.
    assign accept = bus.inValid && inReady_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        serOut_d   = 1'b0;
        serValid_d = 1'b0;
        done_d     = 1'b0;
        inReady_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = SHIFT;
                    shift_d = bus.parIn;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                shift_d = {1'b0, shift_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they land in flops.
        case (state_d)
            IDLE: begin
                inReady_d = 1'b1;
            end
            SHIFT: begin
                serOut_d   = shift_d[0];
                serValid_d = 1'b1;
            end
            DONE: begin
                done_d    = 1'b1;
                inReady_d = 1'b1;
            end
            default: begin
                inReady_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            serOut_q   <= 1'b0;
            serValid_q <= 1'b0;
            done_q     <= 1'b0;
            inReady_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            serOut_q   <= serOut_d;
            serValid_q <= serValid_d;
            done_q     <= done_d;
            inReady_q  <= inReady_d;
        end
    end

    assign bus.serOut   = serOut_q;
    assign bus.serValid = serValid_q;
    assign bus.done     = done_q;
    assign bus.inReady  = inReady_q;

endmodule

`default_nettype wire

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of bits per word; legal values are 2 to 32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rstN, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port parIn, input, WIDTH bits: the parallel word to transmit.
REQ-005 SHALL have port inValid, input, 1 bit: high when parIn holds a word to send.
REQ-006 SHALL have port inReady, output, 1 bit: high when the block can accept a word.
REQ-007 SHALL have port serOut, output, 1 bit: the serial data bit.
REQ-008 SHALL have port serValid, output, 1 bit: high while serOut carries a data bit.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse after the last bit of a word.

Function
REQ-010 SHALL implement a three-state FSM with states IDLE, SHIFT and DONE, plus a WIDTH-bit shift register and a bit counter sized ceil(log2(WIDTH)).
REQ-011 SHALL accept a word on a rising edge where inValid and inReady are both high.
- On accept: load parIn into the shift register, clear the counter, and enter SHIFT.
REQ-012 SHALL drive inReady high in IDLE and in DONE, and low in SHIFT.
REQ-013 SHALL ignore inValid and parIn while in SHIFT.
- A word transmits exactly as captured, even if parIn or inValid change afterwards.
REQ-014 SHALL, in SHIFT, drive serOut equal to shift register bit 0 and drive serValid high.
REQ-015 SHALL, on each SHIFT edge, shift the register right by one, fill bit WIDTH-1 with 0, and increment the counter.
REQ-016 SHALL transmit LSB first, so that a receiver which shifts in at its MSB and is enabled only when serValid is high holds the original word after WIDTH bits.
REQ-017 SHALL leave SHIFT for DONE on the edge where the counter equals WIDTH-1.
- serValid is therefore high for exactly WIDTH consecutive cycles.
REQ-018 SHALL, in DONE, hold done high for exactly one cycle, with serValid low and serOut low.
REQ-019 SHALL, on the edge leaving DONE, enter SHIFT if a word is accepted on that edge, and otherwise enter IDLE.
- Back-to-back words are separated by exactly one non-valid cycle.
REQ-020 SHALL give the following latency for a word accepted at edge k:
- bit 0 on serOut in the cycle after edge k;
- bit WIDTH-1 in the cycle after edge k+WIDTH-1;
- done in the cycle after edge k+WIDTH.
REQ-021 SHALL drive serOut low and serValid low in IDLE.
REQ-022 SHALL decode all outputs from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-023 SHALL, while rstN is low, immediately and independently of clk, force:
- state to IDLE;
- shift register to 0 and counter to 0;
- serOut = 0, serValid = 0, done = 0, inReady = 1.
REQ-024 SHALL, on reset during SHIFT or DONE, discard the partial word and assert no done pulse for it.
REQ-025 SHALL accept a new word on the first rising edge after rstN returns high, if inValid is high.

Verification
REQ-026 Single word: reset, then one-cycle inValid with parIn=0xA5 (WIDTH=8) -> serOut reads 1,0,1,0,0,1,0,1 over 8 cycles with serValid high; done high in cycle 9; inReady high again in cycle 9.
REQ-027 Back-to-back: inValid held high with 0xFF, then parIn changed to 0x00 during the DONE cycle -> 8 ones, one gap cycle with done=1, then 8 zeros, then done, then IDLE.
REQ-028 Ignored request: inValid pulsed with parIn=0x3C during bit 3 of 0x0F -> 0x0F completes unchanged; no second word is sent; inReady stays low throughout SHIFT.
REQ-029 Mid-shift reset: rstN driven low between clock edges during bit 4 of 0x81 -> serOut, serValid and done go 0 without a clock edge; no done pulse follows; after release, 0x01 transmits as 1,0,0,0,0,0,0,0.
REQ-030 Loopback: serOut feeds the serIn of an 8-bit serial-in/parallel-out shift register whose clock is enabled only in serValid cycles; send 0x5A, 0xC3, 0x00, 0xFF -> the register's parallel output equals each sent word at every done pulse.
